fan_alarm_ctrl: RTL

- Downstream consumer of the keyboard-interpretation chain's outputs: `Temps[3:0]`, `Gas`, `Alerta`, `Peligro` and `RESETFSM`.
- Converts the temperature level into a 16-step fan PWM.
- Runs a three-state safety FSM (NORMAL / ALERTA / PELIGRO) that drives the buzzer, alert LED and gas-valve shutoff, with hysteresis and latching.
- All inputs are produced in the same `CLK` domain, so no synchronisers are needed.

---
 rtl/fan_alarm_pkg.sv | 27 ++
 rtl/fan_alarm_ctrl_pwm_gen.sv | 41 ++++
 rtl/fan_alarm_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/fan_alarm_pkg.sv
// Shared constants and types for the fan PWM / safety alarm controller.
package fan_alarm_pkg;

  localparam logic [1:0] ST_NORMAL  = 2'b00;
  localparam logic [1:0] ST_ALERTA  = 2'b01;
  localparam logic [1:0] ST_PELIGRO = 2'b10;

  localparam logic [3:0] DUTY_ALERTA_MIN = 4'd12;
  localparam logic [3:0] DUTY_MAX        = 4'd15;

  typedef enum logic [1:0] {
    S_NORMAL  = ST_NORMAL,
    S_ALERTA  = ST_ALERTA,
    S_PELIGRO = ST_PELIGRO,
    S_ILLEGAL = 2'b11
  } state_t;

  // Fan duty the controller asks for in a given safety state.
  function automatic logic [3:0] req_duty(input state_t st, input logic [3:0] temps);
    case (st)
      S_ALERTA:  return (temps > DUTY_ALERTA_MIN) ? temps : DUTY_ALERTA_MIN;
      S_PELIGRO: return DUTY_MAX;
      default:   return temps;
    endcase
  endfunction

endpackage

// File: rtl/fan_alarm_ctrl_pwm_gen.sv
// 16-step fan PWM: prescaler, step counter, wrap-synchronous duty load, registered compare.
module pwm_gen
  import fan_alarm_pkg::*;
#(
  parameter int PRESC_DIV = 390
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] duty_in,
  input  logic       force_load,
  output logic       pwm_out
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [PW-1:0] presc;
  logic [3:0]    pwm_cnt;
  logic [3:0]    duty_reg;
  logic          tick;
  logic          wrap;

  assign tick = (presc == PW'(PRESC_DIV - 1));
  assign wrap = tick && (pwm_cnt == 4'hF);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      pwm_cnt  <= '0;
      duty_reg <= '0;
      pwm_out  <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 4'd1;
      // Duty only changes at a period boundary unless the alarm demands full fan now.
      if (force_load || wrap) duty_reg <= duty_in;
      pwm_out <= (duty_reg == DUTY_MAX) || (pwm_cnt < duty_reg);
    end
  end

endmodule

// File: rtl/fan_alarm_ctrl.sv
// Safety FSM (NORMAL / ALERTA / PELIGRO) driving buzzer, LED and gas valve, plus fan PWM.
module fan_alarm_ctrl
  import fan_alarm_pkg::*;
#(
  parameter int PRESC_DIV   = 390,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] temps,
  input  logic       gas,
  input  logic       alerta,
  input  logic       peligro,
  input  logic       resetfsm,
  output logic       pwm_fan,
  output logic       buzzer,
  output logic       led_alerta,
  output logic       valve_close,
  output logic [1:0] state_o
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t        state;
  state_t        next_state;
  logic [HW-1:0] hold_cnt;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_d;
  logic          blink;
  logic          blink_d;
  logic          quiet;
  logic          force_load;
  logic [3:0]    duty_req;

  assign quiet = !gas && !alerta;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (peligro) begin
      next_state = S_PELIGRO;
    end else begin
      case (state)
        S_NORMAL:  if (!quiet) next_state = S_ALERTA;
        S_ALERTA:  if (quiet && (resetfsm || hold_cnt == HW'(HOLD_CYCLES - 1)))
                     next_state = S_NORMAL;
        S_PELIGRO: if (resetfsm) next_state = S_NORMAL;
        default:   next_state = S_NORMAL;
      endcase
    end
  end

  // Blink restarts high on ALERTA entry and is parked low outside ALERTA.
  always_comb begin
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (next_state == S_ALERTA) begin
      if (state != S_ALERTA) begin
        blink_d = 1'b1;
      end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_d = !blink;
      end else begin
        blink_cnt_d = blink_cnt + 1'b1;
        blink_d     = blink;
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= S_NORMAL;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      blink       <= 1'b0;
      buzzer      <= 1'b0;
      led_alerta  <= 1'b0;
      valve_close <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_ALERTA && next_state == S_ALERTA && quiet) hold_cnt <= hold_cnt + 1'b1;
      else hold_cnt <= '0;
      blink_cnt   <= blink_cnt_d;
      blink       <= blink_d;
      buzzer      <= (next_state == S_PELIGRO) || blink_d;
      led_alerta  <= (next_state == S_PELIGRO) || blink_d;
      valve_close <= (next_state == S_PELIGRO);
    end
  end

  assign state_o    = state;
  assign duty_req   = req_duty(next_state, temps);
  assign force_load = (next_state == S_PELIGRO) && (state != S_PELIGRO);

  pwm_gen #(.PRESC_DIV(PRESC_DIV)) u_pwm (
    .CLK       (CLK),
    .reset     (reset),
    .duty_in   (duty_req),
    .force_load(force_load),
    .pwm_out   (pwm_fan)
  );

endmodule
